ece429_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the decoder. Keeps the program counter, runs a single-outstanding request/valid handshake with instruction memory, and presents one instruction plus its PC per cycle to decode. Honours a stall from the hazard unit and a redirect from jump/branch resolution. Bubbles are emitted as all-zero words, which decode treats as NOP.

---
 rtl/ece429_fetch_pkg.sv | 20 ++
 rtl/ece429_fetch_if.sv | 13 +
 rtl/ece429_fetch_holdbuf.sv | 41 ++++
 rtl/ece429_fetch.sv | 134 +++++++++++++
 tb/tb_ece429_fetch.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ece429_fetch_pkg.sv
// Shared definitions for the fetch stage: widths, reset PC, bubble word and FSM states.
package ece429_fetch_pkg;

    localparam int unsigned INSN_W = 32;

    localparam logic [0:INSN_W-1] NOP_INSN         = 32'h0000_0000;
    localparam logic [0:INSN_W-1] RESET_PC_DEFAULT = 32'h8002_0000;
    localparam logic [0:INSN_W-1] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [0:INSN_W-1] word_align(input logic [0:INSN_W-1] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ece429_fetch_if.sv
// Instruction-memory bus: single-outstanding request/valid handshake.
interface ece429_fetch_if;
    import ece429_fetch_pkg::*;

    logic              req;
    logic [0:INSN_W-1] addr;
    logic              valid;
    logic [0:INSN_W-1] data;

    modport master (output req, addr, input valid, data);
    modport slave  (input req, addr, output valid, data);

endinterface

// File: rtl/ece429_fetch_holdbuf.sv
// One-entry {insn, pc} skid register that catches a response arriving while decode stalls.
module ece429_fetch_holdbuf
    import ece429_fetch_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [0:INSN_W-1] i_insn,
    input  logic [0:INSN_W-1] i_pc,
    output logic [0:INSN_W-1] o_insn,
    output logic [0:INSN_W-1] o_pc,
    output logic              o_full
);

    logic [0:INSN_W-1] r_insn;
    logic [0:INSN_W-1] r_pc;
    logic              r_full;

    // Clear wins so a redirect in the same cycle discards a capture.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_insn <= NOP_INSN;
            r_pc   <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_insn <= NOP_INSN;
            r_pc   <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_insn <= i_insn;
            r_pc   <= i_pc;
            r_full <= 1'b1;
        end
    end

    assign o_insn = r_insn;
    assign o_pc   = r_pc;
    assign o_full = r_full;

endmodule

// File: rtl/ece429_fetch.sv
// Instruction-fetch stage: PC, memory handshake FSM, squash tracking and the decode-facing register.
module ece429_fetch
    import ece429_fetch_pkg::*;
#(
    parameter logic [0:INSN_W-1] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    ece429_fetch_if.master    imem_bus,
    input  logic              i_stall,
    input  logic              i_redirect_valid,
    input  logic [0:INSN_W-1] i_redirect_pc,
    output logic [0:INSN_W-1] o_insn_out,
    output logic [0:INSN_W-1] o_pc_out,
    output logic              o_insn_valid
);

    fetch_state_e      r_state;
    logic [0:INSN_W-1] r_pc;
    logic              r_squash;
    logic              r_req;
    logic [0:INSN_W-1] r_addr;
    logic [0:INSN_W-1] r_insn;
    logic [0:INSN_W-1] r_pc_out;
    logic              r_insn_valid;

    logic [0:INSN_W-1] w_target;
    logic [0:INSN_W-1] w_pc_next;
    logic              w_out_free;
    logic              w_hb_load;
    logic              w_hb_clear;
    logic [0:INSN_W-1] w_hb_insn;
    logic [0:INSN_W-1] w_hb_pc;
    logic              w_hb_full;

    assign w_target   = word_align(i_redirect_pc);
    assign w_pc_next  = r_pc + PC_STEP;
    assign w_out_free = !r_insn_valid || !i_stall;
    assign w_hb_clear = i_redirect_valid || (r_state == S_HOLD && !i_stall);
    assign w_hb_load  = !i_redirect_valid && r_state == S_WAIT && imem_bus.valid && !r_squash
                        && !w_out_free;

    ece429_fetch_holdbuf u_holdbuf (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_hb_load),
        .i_clear   (w_hb_clear),
        .i_insn    (imem_bus.data),
        .i_pc      (r_addr),
        .o_insn    (w_hb_insn),
        .o_pc      (w_hb_pc),
        .o_full    (w_hb_full)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_squash     <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_insn       <= NOP_INSN;
            r_pc_out     <= '0;
            r_insn_valid <= 1'b0;
        end else if (i_redirect_valid) begin
            r_insn_valid <= 1'b0;
            r_insn       <= NOP_INSN;
            r_pc_out     <= '0;
            r_pc         <= w_target;
            // With a squash already pending the in-flight response still has to drain.
            if (!r_squash) begin
                unique case (r_state)
                    S_WAIT: begin
                        if (imem_bus.valid) r_addr <= w_target;
                        else                r_squash <= 1'b1;
                    end
                    default: begin
                        r_req   <= 1'b1;
                        r_addr  <= w_target;
                        r_state <= S_WAIT;
                    end
                endcase
            end
        end else begin
            if (!i_stall) begin
                r_insn_valid <= 1'b0;
                r_insn       <= NOP_INSN;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_bus.valid) begin
                        if (r_squash) begin
                            r_squash <= 1'b0;
                            r_addr   <= r_pc;
                        end else if (w_out_free) begin
                            r_insn       <= imem_bus.data;
                            r_pc_out     <= r_addr;
                            r_insn_valid <= 1'b1;
                            r_pc         <= w_pc_next;
                            r_addr       <= w_pc_next;
                        end else begin
                            r_pc    <= w_pc_next;
                            r_req   <= 1'b0;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        r_insn       <= w_hb_insn;
                        r_pc_out     <= w_hb_pc;
                        r_insn_valid <= w_hb_full;
                        r_req        <= 1'b1;
                        r_addr       <= r_pc;
                        r_state      <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_bus.req  = r_req;
    assign imem_bus.addr = r_addr;
    assign o_insn_out    = r_insn;
    assign o_pc_out      = r_pc_out;
    assign o_insn_valid  = r_insn_valid;

endmodule

// File: tb/tb_ece429_fetch.sv
// Self-checking bench for ece429_fetch: directed scenarios plus a randomized program-order scoreboard.
module tb_ece429_fetch;

    localparam logic [31:0] RESET_PC = 32'h8002_0000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] insn_out;
    logic [31:0] pc_out;
    logic        insn_valid;

    // Memory model state
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = 32'h0;
    logic        m_busy  = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    int          m_cnt   = 0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;

    // Values the DUT saw / presented at the last rising edge
    logic        p_rst, p_stall, p_redir, p_ov;
    logic [31:0] p_tgt, p_insn, p_pc;

    logic [31:0] exp_next   = RESET_PC;
    int          n_consumed = 0;
    int          checks     = 0;
    int          failures   = 0;

    ece429_fetch_if imem ();
    assign imem.valid = m_valid;
    assign imem.data  = m_data;

    ece429_fetch #(
        .RESET_PC (RESET_PC)
    ) u_dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .imem_bus         (imem),
        .i_stall          (stall),
        .i_redirect_valid (redirect),
        .i_redirect_pc    (redirect_pc),
        .o_insn_out       (insn_out),
        .o_pc_out         (pc_out),
        .o_insn_valid     (insn_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p_rst   <= rst_n;
        p_stall <= stall;
        p_redir <= redirect;
        p_tgt   <= redirect_pc;
        p_insn  <= insn_out;
        p_pc    <= pc_out;
        p_ov    <= insn_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8002_0000) return 32'h2408_0005;
        if (a == 32'h8002_0004) return 32'h2409_0003;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock: wait for the falling edge, run the memory model, then the program-order scoreboard.
    task automatic cycle();
        @(negedge clk);
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_valid  = 1'b0;
            m_data   = 32'h0;
            exp_next = RESET_PC;
        end else begin
            if (m_valid) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
            if (m_busy) begin
                checks++;
                if (imem.req !== 1'b1 || imem.addr !== m_addr) begin
                    failures++;
                    $display("FAIL mem_hold: req=%0b addr=%h, required req=1 addr=%h",
                             imem.req, imem.addr, m_addr);
                end
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_data  = mem_word(m_addr);
                end
            end else if (imem.req === 1'b1) begin
                m_busy = 1'b1;
                m_addr = imem.addr;
                m_cnt  = mem_rand ? int'($urandom_range(4, 1)) : mem_lat;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_data  = mem_word(m_addr);
                end
            end

            if (p_rst === 1'b1) begin
                if (p_redir) begin
                    checks++;
                    if (insn_valid !== 1'b0 || insn_out !== 32'h0 || pc_out !== 32'h0) begin
                        failures++;
                        $display("FAIL redirect_bubble: valid=%0b insn=%h pc=%h, required 0/0/0",
                                 insn_valid, insn_out, pc_out);
                    end
                    exp_next = p_tgt & 32'hFFFF_FFFC;
                end else if (p_stall && p_ov) begin
                    checks++;
                    if (insn_valid !== 1'b1 || insn_out !== p_insn || pc_out !== p_pc) begin
                        failures++;
                        $display("FAIL stall_hold: valid=%0b insn=%h pc=%h, required 1 %h %h",
                                 insn_valid, insn_out, pc_out, p_insn, p_pc);
                    end
                end else if (p_ov) begin
                    checks++;
                    if (p_pc !== exp_next) begin
                        failures++;
                        $display("FAIL consume_order: pc=%h, required %h", p_pc, exp_next);
                    end
                    exp_next = p_pc + 32'd4;
                    n_consumed++;
                end
                checks++;
                if (insn_valid === 1'b1) begin
                    if (insn_out !== mem_word(pc_out)) begin
                        failures++;
                        $display("FAIL insn_data: insn=%h at pc=%h, required %h",
                                 insn_out, pc_out, mem_word(pc_out));
                    end
                end else if (insn_valid !== 1'b0 || insn_out !== 32'h0) begin
                    failures++;
                    $display("FAIL bubble_zero: valid=%0b insn=%h, required 0 00000000",
                             insn_valid, insn_out);
                end
            end else begin
                exp_next = RESET_PC;
            end
        end
    endtask

    // Leaves the DUT in its reset state just after reset release, before the first active edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        mem_rand = 1'b0;
        mem_lat  = 1;
        cycle();
        cycle();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem.req !== 1'b0) begin
            failures++; $display("FAIL reset_req: got %0b, required 0", imem.req);
        end
        checks++;
        if (imem.addr !== 32'h0) begin
            failures++; $display("FAIL reset_addr: got %h, required 00000000", imem.addr);
        end
        checks++;
        if (insn_out !== 32'h0 || pc_out !== 32'h0 || insn_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: insn=%h pc=%h valid=%0b, required zeros",
                     insn_out, pc_out, insn_valid);
        end
        cycle();
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin
            failures++;
            $display("FAIL first_req: req=%0b addr=%h, required 1 %h", imem.req, imem.addr, RESET_PC);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle();
        cycle();
        checks++;
        if (insn_valid !== 1'b1 || insn_out !== 32'h2408_0005 || pc_out !== 32'h8002_0000) begin
            failures++;
            $display("FAIL b2b_first: valid=%0b insn=%h pc=%h, required 1 24080005 80020000",
                     insn_valid, insn_out, pc_out);
        end
        checks++;
        if (imem.addr !== 32'h8002_0004) begin
            failures++; $display("FAIL b2b_addr: got %h, required 80020004", imem.addr);
        end
        cycle();
        checks++;
        if (insn_valid !== 1'b1 || insn_out !== 32'h2409_0003 || pc_out !== 32'h8002_0004) begin
            failures++;
            $display("FAIL b2b_second: valid=%0b insn=%h pc=%h, required 1 24090003 80020004",
                     insn_valid, insn_out, pc_out);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle();
        cycle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (insn_out !== 32'h2408_0005 || pc_out !== 32'h8002_0000 || imem.req !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d: insn=%h pc=%h req=%0b, required 24080005 80020000 0",
                         i, insn_out, pc_out, imem.req);
            end
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (insn_valid !== 1'b1 || pc_out !== 32'h8002_0004 || insn_out !== 32'h2409_0003) begin
            failures++;
            $display("FAIL stall_release: valid=%0b insn=%h pc=%h, required 1 24090003 80020004",
                     insn_valid, insn_out, pc_out);
        end
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h8002_0008) begin
            failures++;
            $display("FAIL stall_resume: req=%0b addr=%h, required 1 80020008", imem.req, imem.addr);
        end
        cycle();
        checks++;
        if (pc_out !== 32'h8002_0008) begin
            failures++; $display("FAIL stall_next: pc=%h, required 80020008", pc_out);
        end
    endtask

    task automatic test_redirect_squash();
        int waited;
        do_reset();
        mem_lat = 3;
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h8002_0103;
        cycle();
        redirect = 1'b0;
        checks++;
        if (imem.addr !== 32'h8002_0000 || insn_valid !== 1'b0) begin
            failures++;
            $display("FAIL squash_hold_addr: addr=%h valid=%0b, required 80020000 0",
                     imem.addr, insn_valid);
        end
        cycle();
        cycle();
        checks++;
        if (imem.addr !== 32'h8002_0100 || insn_valid !== 1'b0) begin
            failures++;
            $display("FAIL squash_target_req: addr=%h valid=%0b, required 80020100 0",
                     imem.addr, insn_valid);
        end
        waited = 0;
        while (insn_valid !== 1'b1 && waited < 10) begin
            cycle();
            waited++;
        end
        checks++;
        if (insn_valid !== 1'b1 || pc_out !== 32'h8002_0100 || waited != 3) begin
            failures++;
            $display("FAIL squash_first_target: valid=%0b pc=%h after %0d cycles, required 1 80020100 after 3",
                     insn_valid, pc_out, waited);
        end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        cycle();
        cycle();
        stall = 1'b1;
        cycle();
        checks++;
        if (imem.req !== 1'b0) begin
            failures++; $display("FAIL hold_no_req: req=%0b, required 0", imem.req);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h8002_0200;
        cycle();
        redirect = 1'b0;
        checks++;
        if (insn_out !== 32'h0 || insn_valid !== 1'b0 || pc_out !== 32'h0) begin
            failures++;
            $display("FAIL hold_redirect_bubble: insn=%h valid=%0b pc=%h, required zeros",
                     insn_out, insn_valid, pc_out);
        end
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h8002_0200) begin
            failures++;
            $display("FAIL hold_redirect_req: req=%0b addr=%h, required 1 80020200",
                     imem.req, imem.addr);
        end
        cycle();
        checks++;
        if (insn_valid !== 1'b1 || pc_out !== 32'h8002_0200) begin
            failures++;
            $display("FAIL hold_discarded: valid=%0b pc=%h, required 1 80020200", insn_valid, pc_out);
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle();
        cycle();
        checks++;
        if (insn_valid !== 1'b1) begin
            failures++; $display("FAIL midreset_pre: valid=%0b, required 1", insn_valid);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem.req !== 1'b0 || imem.addr !== 32'h0 || insn_out !== 32'h0 || pc_out !== 32'h0
            || insn_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: req=%0b addr=%h insn=%h pc=%h valid=%0b, required zeros",
                     imem.req, imem.addr, insn_out, pc_out, insn_valid);
        end
        cycle();
        cycle();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle();
        cycle();
        checks++;
        if (imem.req !== 1'b1 || imem.addr !== RESET_PC) begin
            failures++;
            $display("FAIL midreset_restart: req=%0b addr=%h, required 1 %h",
                     imem.req, imem.addr, RESET_PC);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        checks++;
        if (imem.addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_target: addr=%h, required fffffffc", imem.addr);
        end
        cycle();
        checks++;
        if (imem.addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC || insn_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_addr: addr=%h pc=%h valid=%0b, required 00000000 fffffffc 1",
                     imem.addr, pc_out, insn_valid);
        end
        cycle();
        checks++;
        if (pc_out !== 32'h0 || insn_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_pc: pc=%h valid=%0b, required 00000000 1", pc_out, insn_valid);
        end
    endtask

    task automatic test_random();
        int start;
        do_reset();
        mem_rand = 1'b1;
        start    = n_consumed;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            stall    = ($urandom_range(9, 0) < 3);
            redirect = ($urandom_range(24, 0) == 0);
            if (redirect) begin
                if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15, 0);
                else                           redirect_pc = $urandom();
            end
        end
        stall    = 1'b0;
        redirect = 1'b0;
        cycle();
        mem_rand = 1'b0;
        checks++;
        if (n_consumed - start < 300) begin
            failures++;
            $display("FAIL random_throughput: consumed %0d, required at least 300", n_consumed - start);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_squash();
        test_redirect_hold();
        test_reset_mid();
        test_pc_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
